tx_stream_scheduler: RTL
========================

// Module: tx_stream_scheduler
// PURPOSE
//  Packet-level scheduler in front of the GbemacWrapper in_0 AXI4-Stream TX port.
//  Arbitrates two 32-bit stream sources round-robin, one whole packet per grant.
//  Enforces a programmable inter-packet gap and a maximum packet length (truncate + drain).
//  Replaces ad-hoc pause counters in top-level pattern logic.
// PARAMETERS
//  DATA_W  32  stream data width
//  GAP_W   16  width of gap_cycles
//  LEN_W   12  width of max_len and internal beat counter
// PORTS
//  clk         in   1       single clock; all logic on posedge
//  aresetn     in   1       asynchronous active-low reset
//  enable      in   1       1 = grant new packets; 0 = finish current packet, then idle
//  gap_cycles  in   GAP_W   idle cycles between packets (0 = back-to-back); sampled entering GAP
//  max_len     in   LEN_W   max beats per packet (0 = unlimited); sampled at grant
//  s0_valid/s0_ready/s0_data[DATA_W]/s0_last   source 0 stream (s0_ready is out)
//  s1_valid/s1_ready/s1_data[DATA_W]/s1_last   source 1 stream (s1_ready is out)
//  m_valid     out  1       to in_0_valid
//  m_ready     in   1       from in_0_ready
//  m_data      out  DATA_W  to in_0_bits_data
//  m_last      out  1       to in_0_bits_last
//  grant       out  1       index of source owning current packet
//  busy        out  1       1 in PASS, DRAIN or GAP
// BEHAVIOUR
//  Reset (async, any state): FSM=IDLE, rr_ptr=0, grant=0, beat_cnt=0, gap_cnt=0;
//   m_valid=m_last=busy=0, m_data=0, s0_ready=s1_ready=0. Deassertion sync to clk.
//  States IDLE, PASS, DRAIN, GAP.
//  IDLE: if enable and any s*_valid: grant = rr_ptr if that source valid, else other;
//   latch max_len, beat_cnt=0 -> PASS next cycle. Both valid -> rr_ptr wins.
//  PASS: zero-latency pass-through of granted source: m_valid=sg_valid, m_data=sg_data,
//   sg_ready=m_ready; ungranted ready=0. Beat = m_valid&m_ready; beat_cnt++ per beat.
//   m_last = sg_last | (max_len!=0 & beat_cnt==max_len-1).
//   Beat with sg_last -> GAP. Beat with forced last (sg_last=0) -> DRAIN.
//   max_len==1: first beat always carries m_last=1.
//  DRAIN: m_valid=0, sg_ready=1; discard source beats until one with sg_last -> GAP.
//  GAP: on entry gap_cnt=gap_cycles, rr_ptr=~grant; m_valid=0, both ready=0.
//   gap_cnt==0 -> IDLE next cycle; else decrement, IDLE when it reaches 0
//   (exactly gap_cycles idle cycles after GAP's first cycle).
//  enable=0 mid-packet: no effect until packet (and drain) completes; IDLE then waits.
//  m_data/m_last are don't-care when m_valid=0 but driven 0 outside PASS.
//  Source must hold data stable while valid&!ready (AXI-S rule); no internal buffering.
//  beat_cnt is LEN_W bits, saturates at all-ones when max_len=0 (no wrap-induced last).
// CONFIGURATION
//  TX_STREAM_SCHEDULER_STATS_EN defined: adds outputs
//   pkt_cnt0[15:0], pkt_cnt1[15:0]  out: packets completed per source (++ on m_last beat, wraps)
//   trunc_cnt[7:0]                  out: forced truncations, saturates at 255
//   stats_clr                       in : sync clear of all three (clear wins over increment)
//   all reset to 0 by aresetn.
//  Not defined: these ports and counters are absent; behaviour otherwise identical.
// TESTING
//  1 s0 sends 4-beat pkt (0x10..0x13, last on 0x13), m_ready=1, gap=0 -> m shows 4 beats, m_last on 0x13, grant=0.
//  2 s0,s1 both valid continuously, 3-beat pkts, gap=2 -> grants alternate 0,1,0,1; exactly 2-cycle gap after GAP's first cycle.
//  3 max_len=3, s1 sends 6 beats -> m gets 3 beats, m_last on beat 3; s1 beats 4-6 consumed with m_valid=0; trunc_cnt=1 (STATS_EN).
//  4 m_ready toggles 1/0 during 5-beat pkt -> no beat lost/duplicated; s0_ready mirrors m_ready; data order preserved.
//  5 enable drops on beat 2 of 4 -> beats 3,4 still sent, then IDLE with s*_ready=0 while enable=0.
//  6 aresetn low mid-PASS -> m_valid, s*_ready, busy go 0 same cycle; after release first grant goes to s0.

Source files
------------

// File: rtl/tx_stream_scheduler.sv
// Packet-level round-robin scheduler for two AXI4-Stream sources feeding one TX port.
// Grants one whole packet at a time, enforces an inter-packet gap and an optional
// maximum packet length (excess beats of a truncated packet are drained and dropped).
// Optional statistics counters are compiled in with TX_STREAM_SCHEDULER_STATS_EN.
module tx_stream_scheduler #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned GAP_W  = 16,
  parameter int unsigned LEN_W  = 12
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              enable,
  input  logic [GAP_W-1:0]  gap_cycles,
  input  logic [LEN_W-1:0]  max_len,
  input  logic              s0_valid,
  output logic              s0_ready,
  input  logic [DATA_W-1:0] s0_data,
  input  logic              s0_last,
  input  logic              s1_valid,
  output logic              s1_ready,
  input  logic [DATA_W-1:0] s1_data,
  input  logic              s1_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              grant,
  output logic              busy
`ifdef TX_STREAM_SCHEDULER_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [15:0]       pkt_cnt0,
  output logic [15:0]       pkt_cnt1,
  output logic [7:0]        trunc_cnt
`endif
);

  typedef enum logic [1:0] {StIdle, StPass, StDrain, StGap} state_e;

  state_e            state_q;
  logic              rr_ptr_q;
  logic              grant_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  beat_cnt_q;
  logic [GAP_W-1:0]  gap_cnt_q;

  logic              sg_valid;
  logic [DATA_W-1:0] sg_data;
  logic              sg_last;
  logic              sg_ready;
  logic              in_pass;
  logic              in_drain;
  logic              len_hit;
  logic              beat;
  logic              forced;
  logic              pkt_end;
  logic              pick;

  // Granted-source mux, pass-through outputs and packet-boundary decode
  always_comb begin
    sg_valid = grant_q ? s1_valid : s0_valid;
    sg_data  = grant_q ? s1_data  : s0_data;
    sg_last  = grant_q ? s1_last  : s0_last;
    in_pass  = (state_q == StPass);
    in_drain = (state_q == StDrain);
    len_hit  = (len_q != '0) && (beat_cnt_q == len_q - LEN_W'(1));

    m_valid  = in_pass & sg_valid;
    m_data   = in_pass ? sg_data : '0;
    m_last   = in_pass & (sg_last | len_hit);
    sg_ready = (in_pass & m_ready) | in_drain;
    s0_ready = sg_ready & ~grant_q;
    s1_ready = sg_ready & grant_q;

    beat     = m_valid & m_ready;
    // Truncation only when the source itself is not ending the packet on this beat
    forced   = beat & ~sg_last & len_hit;
    pkt_end  = (beat & sg_last) | (in_drain & sg_valid & sg_last);
    // rr_ptr source wins when valid, otherwise the other one
    pick     = rr_ptr_q ? s1_valid : ~s0_valid;

    grant    = grant_q;
    busy     = (state_q != StIdle);
  end

  // Scheduler FSM: grant, pass, drain truncated tail, inter-packet gap
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= StIdle;
      rr_ptr_q   <= 1'b0;
      grant_q    <= 1'b0;
      len_q      <= '0;
      beat_cnt_q <= '0;
      gap_cnt_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (enable && (s0_valid || s1_valid)) begin
            grant_q    <= pick;
            len_q      <= max_len;
            beat_cnt_q <= '0;
            state_q    <= StPass;
          end
        end
        StPass: begin
          if (beat) begin
            // Saturate so an unlimited packet never produces a wrap-induced last
            if (beat_cnt_q != '1) beat_cnt_q <= beat_cnt_q + LEN_W'(1);
            if (sg_last) begin
              state_q   <= StGap;
              gap_cnt_q <= gap_cycles;
              rr_ptr_q  <= ~grant_q;
            end else if (len_hit) begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          if (pkt_end) begin
            state_q   <= StGap;
            gap_cnt_q <= gap_cycles;
            rr_ptr_q  <= ~grant_q;
          end
        end
        StGap: begin
          // GAP lasts gap_cycles+1 cycles: its first cycle plus gap_cycles more
          if (gap_cnt_q == '0) state_q <= StIdle;
          else                 gap_cnt_q <= gap_cnt_q - GAP_W'(1);
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef TX_STREAM_SCHEDULER_STATS_EN
  logic [15:0] pkt_cnt0_q;
  logic [15:0] pkt_cnt1_q;
  logic [7:0]  trunc_cnt_q;

  // Packet and truncation statistics; synchronous clear beats increment
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      pkt_cnt0_q  <= '0;
      pkt_cnt1_q  <= '0;
      trunc_cnt_q <= '0;
    end else if (stats_clr) begin
      pkt_cnt0_q  <= '0;
      pkt_cnt1_q  <= '0;
      trunc_cnt_q <= '0;
    end else begin
      if (beat && m_last && !grant_q) pkt_cnt0_q <= pkt_cnt0_q + 16'd1;
      if (beat && m_last && grant_q)  pkt_cnt1_q <= pkt_cnt1_q + 16'd1;
      if (forced && trunc_cnt_q != 8'hff) trunc_cnt_q <= trunc_cnt_q + 8'd1;
    end
  end

  assign pkt_cnt0  = pkt_cnt0_q;
  assign pkt_cnt1  = pkt_cnt1_q;
  assign trunc_cnt = trunc_cnt_q;
`endif

endmodule
